// File: rtl/i2s_dac_tx_if.sv
// Stereo sample handshake between a PCM source and the I2S transmitter.
interface i2s_dac_tx_if #(
    parameter int SAMPLE_W = 24
);
    logic [SAMPLE_W-1:0] left_data;
    logic [SAMPLE_W-1:0] right_data;
    logic                sample_valid;
    logic                sample_ready;

    modport master (
        output left_data,
        output right_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  left_data,
        input  right_data,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S transmitter for a WM8731 in slave mode: MCLK, BCLK, LRCK and
// 32-bit-slot serial data with a one-entry stereo holding register.
module i2s_dac_tx #(
    parameter int SAMPLE_W = 24
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              enable,
    i2s_dac_tx_if.slave       smp,
    output logic              AUD_XCK,
    output logic              AUD_BCLK,
    output logic              AUD_DACLRCK,
    output logic              AUD_DACDAT,
    output logic              underrun,
    output logic [7:0]        underrun_cnt
);

    localparam int PAD = 32 - SAMPLE_W;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_e;

    state_e      state_q;
    logic [1:0]  xck_q;
    logic [3:0]  div_q;
    logic [5:0]  slot_q;
    logic [63:0] frame_q;
    logic [63:0] hold_q;
    logic        hold_full_q;
    logic        hold_full_d;
    logic        dat_q;
    logic        underrun_q;
    logic [7:0]  ucnt_q;

    logic [31:0] left32;
    logic [31:0] right32;
    logic        load;
    logic        consume;
    logic        frame_end;

    assign left32  = 32'(smp.left_data) << PAD;
    assign right32 = 32'(smp.right_data) << PAD;

    assign frame_end = (div_q == 4'd15) && (slot_q == 6'd63);
    assign load      = smp.sample_valid && !hold_full_q;
    // Holding is drained either when priming or at a running frame boundary.
    assign consume   = hold_full_q && enable &&
                       ((state_q == IDLE) || (state_q != IDLE && frame_end));

    always_comb begin
        hold_full_d = hold_full_q;
        if (consume) hold_full_d = 1'b0;
        if (load)    hold_full_d = 1'b1;
    end

    assign smp.sample_ready = ~hold_full_q;
    assign AUD_XCK          = xck_q[1];
    assign AUD_BCLK         = div_q[3];
    assign AUD_DACLRCK      = slot_q[5];
    assign AUD_DACDAT       = dat_q;
    assign underrun         = underrun_q;
    assign underrun_cnt     = ucnt_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            xck_q <= 2'd0;
        end else begin
            xck_q <= xck_q + 2'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            if (load) hold_q <= {left32, right32};
            hold_full_q <= hold_full_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_q      <= 4'd0;
            slot_q     <= 6'd0;
            frame_q    <= '0;
            dat_q      <= 1'b0;
            underrun_q <= 1'b0;
            ucnt_q     <= 8'd0;
        end else begin
            underrun_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    div_q   <= 4'd0;
                    slot_q  <= 6'd0;
                    dat_q   <= 1'b0;
                    frame_q <= '0;
                    if (enable) begin
                        state_q <= PRIME;
                        if (hold_full_q) frame_q <= hold_q;
                    end
                end
                PRIME, RUN: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        div_q   <= 4'd0;
                        slot_q  <= 6'd0;
                        dat_q   <= 1'b0;
                        frame_q <= '0;
                    end else begin
                        state_q <= RUN;
                        div_q   <= div_q + 4'd1;
                        if (div_q == 4'd15) begin
                            slot_q <= slot_q + 6'd1;
                            // Next slot k carries F[64-k]; slot 0 gets old F[0].
                            dat_q  <= frame_q[~slot_q];
                            if (slot_q == 6'd63) begin
                                if (hold_full_q) begin
                                    frame_q <= hold_q;
                                end else begin
                                    frame_q    <= '0;
                                    underrun_q <= 1'b1;
                                    if (ucnt_q != 8'd255) ucnt_q <= ucnt_q + 8'd1;
                                end
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed self-checking bench for i2s_dac_tx (SAMPLE_W = 24).
module tb_i2s_dac_tx;

    localparam int SW = 24;

    logic          clk_in = 1'b0;
    logic          rst_n  = 1'b0;
    logic          enable = 1'b0;
    logic          AUD_XCK;
    logic          AUD_BCLK;
    logic          AUD_DACLRCK;
    logic          AUD_DACDAT;
    logic          underrun;
    logic [7:0]    underrun_cnt;

    i2s_dac_tx_if #(.SAMPLE_W(SW)) smp ();

    i2s_dac_tx #(.SAMPLE_W(SW)) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .enable       (enable),
        .smp          (smp),
        .AUD_XCK      (AUD_XCK),
        .AUD_BCLK     (AUD_BCLK),
        .AUD_DACLRCK  (AUD_DACLRCK),
        .AUD_DACDAT   (AUD_DACDAT),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #10 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    logic          bits[$];
    logic          lrs[$];
    int            acc_t[$];
    int            lrf_t[$];
    int            n_under;
    int            feed_n;
    logic [SW-1:0] src_l;
    logic [SW-1:0] src_r;
    logic          bprev;
    logic          lprev;
    int            t0;

    task automatic clear_log();
        bits.delete();
        lrs.delete();
        acc_t.delete();
        lrf_t.delete();
        n_under = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            if (smp.sample_valid) begin
                acc_t.push_back(cyc);
                feed_n = feed_n - 1;
                src_l  = src_l + 1'b1;
                src_r  = src_r + 1'b1;
            end
            if (!bprev && AUD_BCLK) begin
                bits.push_back(AUD_DACDAT);
                lrs.push_back(AUD_DACLRCK);
            end
            if (lprev && !AUD_DACLRCK) lrf_t.push_back(cyc);
            bprev = AUD_BCLK;
            lprev = AUD_DACLRCK;
            if (underrun) n_under++;
            smp.left_data    = src_l;
            smp.right_data   = src_r;
            smp.sample_valid = (feed_n > 0) && smp.sample_ready;
        end
    endtask

    task automatic do_reset();
        enable           = 1'b0;
        feed_n           = 0;
        smp.sample_valid = 1'b0;
        smp.left_data    = '0;
        smp.right_data   = '0;
        rst_n            = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        bprev = 1'b0;
        lprev = 1'b0;
        clear_log();
    endtask

    task automatic start();
        enable = 1'b1;
        clear_log();
        t0 = cyc;
    endtask

    function automatic logic [31:0] word(input int s);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 32; i++) w = {w[30:0], bits[s+i]};
        return w;
    endfunction

    task automatic test_reset();
        logic [12:0] got;
        logic        x[12];
        do_reset();
        @(negedge clk_in);
        got = {AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, underrun, smp.sample_ready, underrun_cnt};
        nvec++;
        if (got !== {4'b0000, 1'b1, 8'd0}) begin
            nerr++;
            $display("FAIL reset_outputs: got %h expected %h", got, {4'b0000, 1'b1, 8'd0});
        end
        for (int i = 0; i < 12; i++) begin
            x[i] = AUD_XCK;
            @(negedge clk_in);
        end
        for (int i = 0; i < 10; i++) begin
            nvec++;
            if (x[i+2] !== ~x[i]) begin
                nerr++;
                $display("FAIL xck_toggle[%0d]: got %b expected %b", i, x[i+2], ~x[i]);
            end
        end
        nvec++;
        if ({AUD_BCLK, AUD_DACLRCK, AUD_DACDAT} !== 3'b000) begin
            nerr++;
            $display("FAIL idle_low: got %b expected 000", {AUD_BCLK, AUD_DACLRCK, AUD_DACDAT});
        end
    endtask

    task automatic test_frame();
        do_reset();
        src_l = 24'h800001;
        src_r = 24'h7FFFFE;
        feed_n = 1;
        run(4);
        nvec++;
        if (smp.sample_ready !== 1'b0) begin
            nerr++;
            $display("FAIL preload_ready: got %b expected 0", smp.sample_ready);
        end
        start();
        run(1045);
        nvec++;
        if (bits.size() != 65) begin
            nerr++;
            $display("FAIL frame_bits: got %0d expected 65", bits.size());
        end else begin
            nvec++;
            if (word(1) !== 32'h80000100) begin
                nerr++;
                $display("FAIL frame_left: got %h expected 80000100", word(1));
            end
            nvec++;
            if (word(33) !== 32'h7FFFFE00) begin
                nerr++;
                $display("FAIL frame_right: got %h expected 7ffffe00", word(33));
            end
            nvec++;
            if ({lrs[0], lrs[31], lrs[32], lrs[63], lrs[64]} !== 5'b00110) begin
                nerr++;
                $display("FAIL frame_lrck: got %b expected 00110",
                         {lrs[0], lrs[31], lrs[32], lrs[63], lrs[64]});
            end
        end
        nvec++;
        if (lrf_t.size() != 1 || lrf_t[0] != t0 + 1025) begin
            nerr++;
            $display("FAIL frame_period: got %0d expected %0d",
                     lrf_t.size() > 0 ? lrf_t[0] - t0 : -1, 1025);
        end
        nvec++;
        if (n_under != 1 || underrun_cnt !== 8'd1) begin
            nerr++;
            $display("FAIL frame_underrun: got %0d/%0d expected 1/1", n_under, underrun_cnt);
        end
    endtask

    task automatic test_stream();
        logic [SW-1:0] k;
        do_reset();
        src_l = 24'h000000;
        src_r = 24'hA00000;
        feed_n = 1000;
        run(10);
        start();
        run(4126);
        nvec++;
        if (bits.size() < 257) begin
            nerr++;
            $display("FAIL stream_bits: got %0d expected >=257", bits.size());
        end else begin
            for (int f = 0; f < 4; f++) begin
                k = SW'(f);
                nvec++;
                if (word(64*f+1) !== {k, 8'h00}) begin
                    nerr++;
                    $display("FAIL stream_left[%0d]: got %h expected %h", f, word(64*f+1), {k, 8'h00});
                end
                nvec++;
                if (word(64*f+33) !== {24'hA00000 + k, 8'h00}) begin
                    nerr++;
                    $display("FAIL stream_right[%0d]: got %h expected %h",
                             f, word(64*f+33), {24'hA00000 + k, 8'h00});
                end
            end
        end
        nvec++;
        if (n_under != 0) begin
            nerr++;
            $display("FAIL stream_underrun: got %0d expected 0", n_under);
        end
        nvec++;
        if (acc_t.size() != 5 || acc_t[0] != t0 + 2) begin
            nerr++;
            $display("FAIL stream_accepts: got %0d expected 5", acc_t.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                nvec++;
                if (acc_t[i+1] - acc_t[i] != 1024) begin
                    nerr++;
                    $display("FAIL stream_rate[%0d]: got %0d expected 1024", i, acc_t[i+1] - acc_t[i]);
                end
            end
        end
    endtask

    task automatic test_starve();
        int u0;
        do_reset();
        src_l = 24'h123456;
        src_r = 24'h654321;
        feed_n = 2;
        run(10);
        start();
        run(4126);
        nvec++;
        if (bits.size() < 257) begin
            nerr++;
            $display("FAIL starve_bits: got %0d expected >=257", bits.size());
        end else begin
            nvec++;
            if ({word(1), word(33)} !== {32'h12345600, 32'h65432100}) begin
                nerr++;
                $display("FAIL starve_f0: got %h expected 1234560065432100", {word(1), word(33)});
            end
            nvec++;
            if ({word(65), word(97)} !== {32'h12345700, 32'h65432200}) begin
                nerr++;
                $display("FAIL starve_f1: got %h expected 1234570065432200", {word(65), word(97)});
            end
            nvec++;
            if ({word(129), word(161), word(193), word(225)} !== 128'd0) begin
                nerr++;
                $display("FAIL starve_zero: got %h expected 0",
                         {word(129), word(161), word(193), word(225)});
            end
        end
        nvec++;
        if (n_under != 3 || underrun_cnt !== 8'd3) begin
            nerr++;
            $display("FAIL starve_count: got %0d/%0d expected 3/3", n_under, underrun_cnt);
        end
        // Skip ahead to near saturation instead of running 250 more frames.
        force dut.ucnt_q = 8'd253;
        @(negedge clk_in);
        release dut.ucnt_q;
        u0 = n_under;
        run(2048);
        nvec++;
        if (underrun_cnt !== 8'd255) begin
            nerr++;
            $display("FAIL sat_reach: got %0d expected 255", underrun_cnt);
        end
        run(1024);
        nvec++;
        if (underrun_cnt !== 8'd255 || n_under - u0 != 3) begin
            nerr++;
            $display("FAIL sat_hold: got %0d/%0d expected 255/3", underrun_cnt, n_under - u0);
        end
    endtask

    task automatic test_disable();
        int nb;
        do_reset();
        src_l = 24'hFFFFFE;
        src_r = 24'h0F0F0F;
        feed_n = 2;
        run(10);
        start();
        run(330);
        nvec++;
        if ({AUD_DACLRCK, AUD_DACDAT, smp.sample_ready} !== 3'b010) begin
            nerr++;
            $display("FAIL dis_before: got %b expected 010",
                     {AUD_DACLRCK, AUD_DACDAT, smp.sample_ready});
        end
        enable = 1'b0;
        run(1);
        nvec++;
        if ({AUD_BCLK, AUD_DACLRCK, AUD_DACDAT} !== 3'b000) begin
            nerr++;
            $display("FAIL dis_low: got %b expected 000", {AUD_BCLK, AUD_DACLRCK, AUD_DACDAT});
        end
        nb = bits.size();
        run(200);
        nvec++;
        if (n_under != 0 || bits.size() != nb || smp.sample_ready !== 1'b0) begin
            nerr++;
            $display("FAIL dis_idle: got %0d/%0d/%b expected 0/0/0",
                     n_under, bits.size() - nb, smp.sample_ready);
        end
        start();
        run(1054);
        nvec++;
        if (bits.size() < 65) begin
            nerr++;
            $display("FAIL reen_bits: got %0d expected >=65", bits.size());
        end else begin
            nvec++;
            if ({word(1), word(33)} !== {32'hFFFFFF00, 32'h0F0F1000}) begin
                nerr++;
                $display("FAIL reen_data: got %h expected ffffff000f0f1000", {word(1), word(33)});
            end
        end
        nvec++;
        if (lrf_t.size() < 1 || lrf_t[0] != t0 + 1025 || n_under != 1) begin
            nerr++;
            $display("FAIL reen_frame: got %0d/%0d expected 1025/1",
                     lrf_t.size() > 0 ? lrf_t[0] - t0 : -1, n_under);
        end
    endtask

    task automatic test_async_reset();
        logic [13:0] got;
        bit          hit;
        do_reset();
        start();
        run(1100);
        src_l = 24'h555555;
        src_r = 24'h2AAAAA;
        feed_n = 1;
        run(5);
        nvec++;
        if ({smp.sample_ready, underrun_cnt} !== {1'b0, 8'd1}) begin
            nerr++;
            $display("FAIL arst_pre: got %h expected 001", {smp.sample_ready, underrun_cnt});
        end
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk_in);
            hit = AUD_XCK && AUD_BCLK;
        end
        nvec++;
        if (!hit) begin
            nerr++;
            $display("FAIL arst_wait: got timeout expected xck&bclk high");
        end
        #3 rst_n = 1'b0;
        #1;
        got = {AUD_XCK, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, underrun, smp.sample_ready, underrun_cnt};
        nvec++;
        if (got !== {5'b00000, 1'b1, 8'd0}) begin
            nerr++;
            $display("FAIL arst_outputs: got %h expected %h", got, {5'b00000, 1'b1, 8'd0});
        end
        enable = 1'b0;
        @(negedge clk_in);
        rst_n = 1'b1;
        run(3);
        nvec++;
        if ({smp.sample_ready, AUD_BCLK} !== 2'b10) begin
            nerr++;
            $display("FAIL arst_hold_clr: got %b expected 10", {smp.sample_ready, AUD_BCLK});
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_stream();
        test_starve();
        test_disable();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/i2s_dac_tx.md
# i2s_dac_tx

I2S transmitter feeding stereo PCM samples to the WM8731 DAC. The codec is configured in slave mode, I2S format, 32-bit word length, 256fs normal mode. This block generates the codec master clock (AUD_XCK), bit clock (AUD_BCLK) and DAC LR clock (AUD_DACLRCK), and serializes samples onto AUD_DACDAT. It sits downstream of the codec control/IIC configuration path, and `enable` is driven once configuration completes. Upstream sample sources hand it one stereo sample per frame over a valid/ready handshake.

## Interface
- SAMPLE_W, 24 — input sample width (16..32); two's complement, MSB-aligned into a 32-bit slot, LSBs zero-padded.
- clk_in  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  1: run serial interface; 0: hold BCLK/LRCK/DAT low, counters at 0.
- left_data  in  SAMPLE_W  left-channel sample.
- right_data  in  SAMPLE_W  right-channel sample.
- sample_valid  in  1  upstream holds a stereo sample.
- sample_ready  out  1  holding register empty; transfer on valid&ready at posedge clk_in.
- AUD_XCK  out  1  codec MCLK = clk_in/4 (12.5 MHz, fs ≈ 48.83 kHz).
- AUD_BCLK  out  1  bit clock = clk_in/16 (64 fs).
- AUD_DACLRCK  out  1  0 = left slot, 1 = right slot.
- AUD_DACDAT  out  1  serial data, MSB first, I2S one-BCLK delay.
- underrun  out  1  one-clk pulse when a frame starts with no sample held.
- underrun_cnt  out  8  saturating count of underruns (stays at 255).

## Operation
- AUD_XCK: free-running 2-bit counter MSB; runs whenever rst_n high, independent of enable.
- div_cnt (4 bit, 0..15): BCLK = div_cnt[3]; low on counts 0..7, high on counts 8..15.
- slot_cnt (6 bit, 0..63): increments when div_cnt==15; 0..63 wraps. AUD_DACLRCK = slot_cnt[5].
- Frame register F[63:0] = {L32, R32}; each half is {sample, (32-SAMPLE_W) zeros}.
- DACDAT in slot k (k≥1) = F[64-k]; slot 0 = F_prev[0] (always 0 with padding). So left MSB is in slot 1, right MSB in slot 33, matching I2S.
- DACDAT updates when div_cnt==0, i.e. at the BCLK falling edge. The codec samples on the rising edge, giving 8 clk of setup and hold.
- Holding register: loaded on sample_valid & sample_ready; hold_full set. sample_ready = ~hold_full (combinational from register).
- Frame boundary: div_cnt==15 && slot_cnt==63.
  - If hold_full: F <= holding and hold_full clears.
  - Otherwise F <= 0, underrun pulses and underrun_cnt increments.
- Simultaneous load and boundary: boundary consumes the old content; new data is written the same cycle and hold_full stays 1. This case can only occur if hold_full was 0, so the new sample goes to holding and the frame gets zeros plus underrun.
- States:
  - IDLE (enable=0): div_cnt/slot_cnt = 0; BCLK, LRCK, DAT = 0; F = 0; the holding register still accepts one sample.
  - IDLE→PRIME when enable=1: load F from holding (or zeros, no underrun flagged) on the first cycle.
  - PRIME→RUN after 1 cycle.
  - RUN→IDLE immediately when enable=0, mid-frame included. The frame is truncated and no underrun is flagged.
- Reset: all outputs 0 except sample_ready = 1; hold_full = 0, F = 0, underrun_cnt = 0, state IDLE.

## Timing
- Frame = 64 BCLK = 1024 clk_in; one stereo sample is consumed per frame.
- Latency: sample accepted at cycle t with hold_full=0 reaches its left MSB on DACDAT at the start of slot 1 of the next frame after t. The first RUN frame after enable uses the primed data.
- DACLRCK and DACDAT change together on BCLK falling edges only. BCLK duty is 50%.
- sample_ready falls the cycle after acceptance and rises the cycle after a frame boundary.

## Test plan
- Reset then release, enable=0 → XCK toggles every 2 clk; BCLK/LRCK/DAT low; sample_ready=1; underrun_cnt=0.
- SAMPLE_W=24, preload L=24'h800001, R=24'h7FFFFE, enable=1 → capture 64 bits on BCLK rising edges. Slot 1..32 carry 32'h80000100 and slot 33..64 carry 32'h7FFFFE00; LRCK rises at slot 32; the next frame starts at clk 1024.
- Continuous streaming: source asserts valid every time ready is high, ramp values 0,1,2,… → decoded samples are in order, no gaps, underrun never pulses, and exactly 1 acceptance per 1024 clk.
- Starve after 2 samples → frames 3+ transmit zeros and underrun pulses once per frame. Force 300 starved frames → underrun_cnt saturates at 255.
- enable deasserted at slot 20 → BCLK/LRCK/DAT low the next cycle, counters 0, no underrun. Re-enable → first frame starts at slot 0 with the held sample.
- Assert rst_n low mid-frame with hold_full=1 → all outputs take reset values asynchronously and holding is cleared (sample_ready=1).
